uart_fifo_device: RTL and testbench
===================================

# uart_fifo_device

Buffered, parametrised successor to the single-byte UART peripheral on the Z80 I/O bus. It provides a full-duplex 8N1/8E1/8O1/8x2 serial port. TX and RX FIFOs have configurable depth, RX uses 16x oversampling, and sticky error flags are exposed through three I/O-mapped registers at a parameterised base address.

## Interface
- `CLK_HZ`, 25000000: system clock frequency.
- `BAUD`, 115200: line rate.
- `BASE`, 8'h10: I/O base address; registers occupy BASE+0..BASE+2.
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, 2..256.
- `clk`  in  1: system clock. One clock domain for the whole block.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: I/O strobe from the CPU bus.
- `address`  in  8: I/O port address.
- `write`  in  1: 1 = write access, 0 = read access.
- `dbus_in`  in  8: write data.
- `dbus_out`  out  8: read data, registered.
- `rx`  in  1: serial input, asynchronous to `clk`.
- `tx`  out  1: serial output, idle high.

## Operation
- Bus access:
  - An access is performed once, in the clk cycle where `enable` is high and was low in the previous cycle (internal edge detect).
  - A held strobe never pops or pushes twice.
  - Addresses outside BASE..BASE+2 are ignored.
- STATUS (BASE+0):
  - Read returns {2'b0, frame_err, parity_err, rx_overrun, rx_avail, tx_busy, tx_full}.
  - tx_busy = TX FIFO non-empty or shifter active.
  - Any write clears the three sticky error bits.
- DATA (BASE+1):
  - Write pushes `dbus_in` into the TX FIFO. If the FIFO is full the byte is silently dropped.
  - Read pops the RX FIFO and returns the byte. If the FIFO is empty it returns 8'h00 and nothing changes.
- CTRL (BASE+2), read/write, reset 0:
  - bits[1:0] parity: 00 none, 01 even, 10 odd, 11 treated as none.
  - bit2 selects two stop bits.
  - Bits[7:3] read 0.
- Tick generator:
  - Free-running counter emits a 1-cycle `tick` every DIV = CLK_HZ/(BAUD*16) clocks.
  - Elaboration error if DIV < 1.
  - One bit time = 16 ticks.
- TX FSM IDLE -> START -> DATA(8, LSB first) -> PARITY (skipped if none) -> STOP1 -> STOP2 (only if CTRL[2]) -> IDLE.
  - In IDLE with the FIFO non-empty: pop the FIFO, latch the byte and the current CTRL, then enter START.
  - Each state lasts exactly 16 ticks.
  - Even parity = XOR of data bits; odd = its inverse.
  - The next byte starts back-to-back with no extra idle time.
- RX FSM IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - `rx` passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts the frame. The line is re-checked after 8 ticks (mid start bit); if it is high, return to IDLE as a glitch and write nothing.
  - Subsequent bits are sampled every 16 ticks.
  - A parity mismatch sets parity_err. A stop sample of 0 sets frame_err. In both cases the byte is still pushed.
  - After the stop sample the FSM returns to IDLE; only one stop bit is checked.
- Overrun: a byte that completes while the RX FIFO is full is dropped and rx_overrun is set.
- Simultaneous pop and push on a full RX FIFO: both take effect, count unchanged, no overrun.
- Simultaneous push and pop on the TX FIFO: both take effect.
- CTRL writes during a frame affect only the next frame.

## Timing
- Reset values:
  - `tx` = 1, `dbus_out` = 8'h00.
  - FIFOs empty, CTRL = 0, sticky flags 0.
  - Both FSMs IDLE, tick counter 0.
  - Reset mid-frame forces `tx` high immediately, regardless of `clk`.
- `dbus_out` is valid the clk edge after the access cycle and holds until the next read.
- TX latency: push at edge N; the FSM pops at N+1; `tx` falls at N+2.
- A 10-bit 8N1 frame lasts 160 ticks.
- RX: the byte is visible (rx_avail = 1) 1 cycle after the stop-bit sample tick.
- STATUS reflects FIFO state updated by the previous edge.

## Structure
- Package `uart_pkg`:
  - Register offsets (REG_STATUS = 0, REG_DATA = 1, REG_CTRL = 2).
  - Parity-mode constants.
  - TX and RX state enums.
  - STATUS bit indices.
- Sub-module `uart_fifo` (DEPTH, WIDTH = 8):
  - Synchronous FIFO with push, pop, dout, full, empty.
  - Read-first on simultaneous push and pop.
  - Instantiated twice.
- The tick generator and both FSMs live in the top module.

## Test plan
- Reset, read STATUS -> 8'h00.
- With CTRL = 0 and DIV = 1, write 8'hA5 to DATA -> `tx` shows start 0, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then stop 1; tx_busy = 0 after 160 ticks.
- Loop `tx` to `rx` with CTRL = 8'h05 (even parity, two stop bits) and send 8'h3C -> DATA read returns 8'h3C; STATUS = 8'h00 after the read.
- Drive a frame with a wrong parity bit, then a frame with a 0 stop bit -> parity_err and frame_err set, bytes stored; STATUS write clears both.
- Send FIFO_DEPTH+1 frames without reading -> rx_overrun = 1; the first FIFO_DEPTH bytes read back in order; the extra byte is lost.
- Push FIFO_DEPTH+1 bytes rapidly -> tx_full asserted, last byte dropped. Assert `reset` mid-frame -> `tx` = 1 immediately and STATUS = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helpers for the buffered UART.
package uart_pkg;

    // Register offsets relative to the I/O base address
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // Parity modes held in CTRL[1:0]; 2'b11 behaves as no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // STATUS register bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_RX_AVAIL   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_PARITY_ERR = 4;
    localparam int ST_FRAME_ERR  = 5;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its inverse
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on o_dout,
// so a pop returns the old head even when a push happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_device.sv
// Buffered full-duplex UART on an 8-bit I/O bus: STATUS/DATA/CTRL registers,
// TX and RX FIFOs, shared 16x tick generator, TX and RX framing FSMs.
module uart_fifo_device
    import uart_pkg::*;
#(
    parameter int         CLK_HZ     = 25000000,
    parameter int         BAUD       = 115200,
    parameter logic [7:0] BASE       = 8'h10,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] address,
    input  logic       write,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    input  logic       rx,
    output logic       tx
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV < 1) ? 1 : $clog2(DIV + 1);

    localparam logic [7:0] ADDR_STATUS = BASE + {6'd0, REG_STATUS};
    localparam logic [7:0] ADDR_DATA   = BASE + {6'd0, REG_DATA};
    localparam logic [7:0] ADDR_CTRL   = BASE + {6'd0, REG_CTRL};

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_fifo_device: CLK_HZ/(BAUD*16) must be at least 1");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_fifo_device: FIFO_DEPTH must be a power of two in 2..256");
        end
    endgenerate

    // ---------------- bus decode ----------------
    logic       r_en_prev;
    logic       w_access, w_rd, w_wr;
    logic       w_sel_status, w_sel_data, w_sel_ctrl;
    logic [2:0] r_ctrl;
    logic       r_frame_err, r_parity_err, r_overrun;
    logic [7:0] r_dbus_out;
    logic [7:0] w_status;

    assign w_access     = enable & ~r_en_prev;
    assign w_rd         = w_access & ~write;
    assign w_wr         = w_access & write;
    assign w_sel_status = (address == ADDR_STATUS);
    assign w_sel_data   = (address == ADDR_DATA);
    assign w_sel_ctrl   = (address == ADDR_CTRL);
    assign dbus_out     = r_dbus_out;

    // ---------------- FIFOs ----------------
    logic       w_tx_pop, w_txf_full, w_txf_empty;
    logic [7:0] w_txf_dout;
    logic       w_rx_push, w_rxf_pop, w_rxf_full, w_rxf_empty;
    logic [7:0] w_rxf_dout;
    logic [7:0] r_rx_data;

    assign w_rxf_pop = w_rd & w_sel_data & ~w_rxf_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr & w_sel_data),
        .i_din   (dbus_in),
        .i_pop   (w_tx_pop),
        .o_dout  (w_txf_dout),
        .o_full  (w_txf_full),
        .o_empty (w_txf_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_din   (r_rx_data),
        .i_pop   (w_rxf_pop),
        .o_dout  (w_rxf_dout),
        .o_full  (w_rxf_full),
        .o_empty (w_rxf_empty)
    );

    // ---------------- tick generator ----------------
    logic [CW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == CW'(DIV - 1));

    // Free-running divider producing one tick per 1/16 bit time
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------- TX FSM ----------------
    tx_state_t  r_tx_state, w_tx_state_next;
    logic [3:0] r_tx_tick, w_tx_tick_next;
    logic [2:0] r_tx_bit, w_tx_bit_next;
    logic [7:0] r_tx_data, w_tx_data_next;
    logic [2:0] r_tx_ctrl, w_tx_ctrl_next;
    logic       r_tx, w_tx_line, w_tx_load, w_tx_bit_done;

    assign w_tx_bit_done = w_tick & (r_tx_tick == 4'd15);
    assign tx            = r_tx;

    // TX next state: each state spans 16 ticks; the end of a frame reloads directly so frames run back-to-back
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_tick_next  = r_tx_tick;
        w_tx_bit_next   = r_tx_bit;
        w_tx_data_next  = r_tx_data;
        w_tx_ctrl_next  = r_tx_ctrl;
        w_tx_pop        = 1'b0;
        w_tx_line       = 1'b1;
        w_tx_load       = 1'b0;
        if (r_tx_state != TX_IDLE && w_tick) w_tx_tick_next = r_tx_tick + 4'd1;
        case (r_tx_state)
            TX_IDLE: w_tx_load = 1'b1;
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_done) w_tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx_line = r_tx_data[r_tx_bit];
                if (w_tx_bit_done) begin
                    w_tx_bit_next = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7)
                        w_tx_state_next = parity_enabled(r_tx_ctrl[1:0]) ? TX_PARITY : TX_STOP1;
                end
            end
            TX_PARITY: begin
                w_tx_line = parity_bit(r_tx_data, r_tx_ctrl[1:0]);
                if (w_tx_bit_done) w_tx_state_next = TX_STOP1;
            end
            TX_STOP1: begin
                if (w_tx_bit_done) begin
                    if (r_tx_ctrl[2]) w_tx_state_next = TX_STOP2;
                    else              w_tx_load = 1'b1;
                end
            end
            TX_STOP2: if (w_tx_bit_done) w_tx_load = 1'b1;
            default:  w_tx_state_next = TX_IDLE;
        endcase
        if (w_tx_load) begin
            if (!w_txf_empty) begin
                w_tx_pop        = 1'b1;
                w_tx_data_next  = w_txf_dout;
                w_tx_ctrl_next  = r_ctrl;
                w_tx_tick_next  = 4'd0;
                w_tx_bit_next   = 3'd0;
                w_tx_state_next = TX_START;
            end else begin
                w_tx_state_next = TX_IDLE;
            end
        end
    end

    // TX state register; the line output is registered so reset drives it high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_data  <= 8'h00;
            r_tx_ctrl  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_tick  <= w_tx_tick_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_ctrl  <= w_tx_ctrl_next;
            r_tx       <= w_tx_line;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t  r_rx_state, w_rx_state_next;
    logic [3:0] r_rx_tick, w_rx_tick_next;
    logic [2:0] r_rx_bit, w_rx_bit_next;
    logic [7:0] w_rx_data_next;
    logic [1:0] r_rx_par, w_rx_par_next;
    logic       r_rx_par_bad, w_rx_par_bad_next;
    logic [1:0] r_rx_sync;
    logic       r_rx_prev;
    logic       w_rx_line, w_rx_fall, w_rx_sample;
    logic       w_set_frame, w_set_parity, w_set_overrun;

    assign w_rx_line     = r_rx_sync[1];
    assign w_rx_fall     = r_rx_prev & ~w_rx_line;
    assign w_rx_sample   = w_tick & (r_rx_tick == 4'd15);
    assign w_set_overrun = w_rx_push & w_rxf_full & ~w_rxf_pop;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
            r_rx_prev <= w_rx_line;
        end
    end

    // RX next state: verify mid start bit after 8 ticks, then sample every 16 ticks
    always_comb begin
        w_rx_state_next   = r_rx_state;
        w_rx_tick_next    = r_rx_tick;
        w_rx_bit_next     = r_rx_bit;
        w_rx_data_next    = r_rx_data;
        w_rx_par_next     = r_rx_par;
        w_rx_par_bad_next = r_rx_par_bad;
        w_rx_push         = 1'b0;
        w_set_frame       = 1'b0;
        w_set_parity      = 1'b0;
        if (r_rx_state != RX_IDLE && w_tick) w_rx_tick_next = r_rx_tick + 4'd1;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_next   = RX_START;
                    w_rx_tick_next    = 4'd0;
                    w_rx_bit_next     = 3'd0;
                    w_rx_par_next     = r_ctrl[1:0];
                    w_rx_par_bad_next = 1'b0;
                end
            end
            RX_START: begin
                if (w_tick && r_rx_tick == 4'd7) begin
                    w_rx_tick_next = 4'd0;
                    if (w_rx_line) w_rx_state_next = RX_IDLE;
                    else           w_rx_state_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_sample) begin
                    w_rx_data_next = {w_rx_line, r_rx_data[7:1]};
                    w_rx_bit_next  = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7)
                        w_rx_state_next = parity_enabled(r_rx_par) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rx_sample) begin
                    w_rx_par_bad_next = (w_rx_line != parity_bit(r_rx_data, r_rx_par));
                    w_rx_state_next   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_push       = 1'b1;
                    w_set_frame     = ~w_rx_line;
                    w_set_parity    = r_rx_par_bad;
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_tick    <= 4'd0;
            r_rx_bit     <= 3'd0;
            r_rx_data    <= 8'h00;
            r_rx_par     <= PAR_NONE;
            r_rx_par_bad <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_rx_tick    <= w_rx_tick_next;
            r_rx_bit     <= w_rx_bit_next;
            r_rx_data    <= w_rx_data_next;
            r_rx_par     <= w_rx_par_next;
            r_rx_par_bad <= w_rx_par_bad_next;
        end
    end

    // ---------------- registers ----------------
    // STATUS word assembled from live FIFO state and sticky flags
    always_comb begin
        w_status                = 8'h00;
        w_status[ST_TX_FULL]    = w_txf_full;
        w_status[ST_TX_BUSY]    = ~w_txf_empty | (r_tx_state != TX_IDLE);
        w_status[ST_RX_AVAIL]   = ~w_rxf_empty;
        w_status[ST_RX_OVERRUN] = r_overrun;
        w_status[ST_PARITY_ERR] = r_parity_err;
        w_status[ST_FRAME_ERR]  = r_frame_err;
    end

    // Strobe edge detect, CTRL register and sticky flags (a new error wins over a same-cycle clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_prev    <= 1'b0;
            r_ctrl       <= 3'd0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_en_prev <= enable;
            if (w_wr && w_sel_ctrl) r_ctrl <= dbus_in[2:0];
            if (w_wr && w_sel_status) begin
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
                r_overrun    <= 1'b0;
            end
            if (w_set_frame)   r_frame_err  <= 1'b1;
            if (w_set_parity)  r_parity_err <= 1'b1;
            if (w_set_overrun) r_overrun    <= 1'b1;
        end
    end

    // Read data register, updated only by reads of a mapped address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbus_out <= 8'h00;
        end else if (w_rd) begin
            if (w_sel_status)    r_dbus_out <= w_status;
            else if (w_sel_data) r_dbus_out <= w_rxf_empty ? 8'h00 : w_rxf_dout;
            else if (w_sel_ctrl) r_dbus_out <= {5'b00000, r_ctrl};
        end
    end

endmodule

// File: tb/tb_uart_fifo_device.sv
// Scoreboard bench for uart_fifo_device: bus reads and TX frames are queued
// as expectations; two monitors compare them as the DUT produces output.
module tb_uart_fifo_device;

    localparam int         CLK_HZ   = 16;
    localparam int         BAUD     = 1;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] BASE     = 8'h10;
    localparam logic [7:0] A_STATUS = 8'h10;
    localparam logic [7:0] A_DATA   = 8'h11;
    localparam logic [7:0] A_CTRL   = 8'h12;

    logic       clk = 1'b0;
    logic       reset, enable, write;
    logic [7:0] address, dbus_in, dbus_out;
    logic       rx, tx, rx_drv, rx_loop, tx_mon_en;

    assign rx = rx_loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_device #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .address(address),
        .write(write), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .rx(rx), .tx(tx)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    logic [7:0] exp_q[$];
    string      name_q[$];
    frame_t     tx_q[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end else begin
            $display("ok   %s got=%h", name, got);
        end
    endtask

    // Bench-side copy of the access rule: one read per rising strobe to a mapped address
    logic tb_en_prev, rd_seen;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_en_prev <= 1'b0;
            rd_seen    <= 1'b0;
        end else begin
            tb_en_prev <= enable;
            rd_seen    <= enable && !tb_en_prev && !write &&
                          (address >= BASE) && (address <= BASE + 8'd2);
        end
    end

    // Read monitor: compares dbus_out the cycle after each read access
    initial begin
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", {8'h00, dbus_out}, 16'hFFFF);
                end else begin
                    check(name_q.pop_front(), {8'h00, dbus_out}, {8'h00, exp_q.pop_front()});
                end
            end
        end
    end

    // TX monitor: on each start edge, sample mid-bit every 16 cycles (one tick per clock)
    initial begin
        frame_t      f;
        logic [11:0] got;
        forever begin
            @(negedge tx);
            if (tx_mon_en) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", 16'h0000, 16'h0001);
                end else begin
                    f   = tx_q.pop_front();
                    got = 12'h000;
                    repeat (8) @(negedge clk);
                    got[0] = tx;
                    for (int i = 1; i < f.len; i++) begin
                        repeat (16) @(negedge clk);
                        got[i] = tx;
                    end
                    check("tx_frame", {4'h0, got}, {4'h0, f.bits});
                end
            end
        end
    end

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        enable = 1'b1; write = 1'b1; address = addr; dbus_in = data;
        @(negedge clk);
        enable = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp, input string name, input int hold);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        enable = 1'b1; write = 1'b0; address = addr;
        repeat (hold) @(negedge clk);
        enable = 1'b0;
    endtask

    // Drive a serial frame on rx, bit 0 first, 16 clocks per bit
    task automatic send_rx(input logic [11:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] ov_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        reset = 1'b1; enable = 1'b0; write = 1'b0; address = 8'h00; dbus_in = 8'h00;
        rx_drv = 1'b1; rx_loop = 1'b0; tx_mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_dbus_out", {8'h00, dbus_out}, 16'h0000);
        reset = 1'b0;
        bus_read(A_STATUS, 8'h00, "reset_status", 1);
        bus_read(A_CTRL,   8'h00, "reset_ctrl", 1);
        bus_read(A_DATA,   8'h00, "empty_rx_read", 1);

        // 8N1 transmit of A5: start 0, 1,0,1,0,0,1,0,1, stop 1
        tx_q.push_back('{bits: 12'b00_1_10100101_0, len: 10});
        bus_write(A_DATA, 8'hA5);
        bus_read(A_STATUS, 8'h02, "tx_busy_after_push", 1);
        repeat (200) @(negedge clk);
        bus_read(A_STATUS, 8'h00, "tx_idle_after_frame", 1);

        // Loopback, even parity, two stops: 3C has four ones so parity bit 0
        rx_loop = 1'b1;
        bus_write(A_CTRL, 8'h05);
        bus_read(A_CTRL, 8'h05, "ctrl_readback", 1);
        tx_q.push_back('{bits: 12'b1_1_0_00111100_0, len: 12});
        bus_write(A_DATA, 8'h3C);
        repeat (260) @(negedge clk);
        bus_read(A_STATUS, 8'h04, "loop_rx_avail", 1);
        bus_read(A_DATA,   8'h3C, "loop_rx_data", 1);
        bus_read(A_STATUS, 8'h00, "loop_status_after_read", 1);
        rx_loop = 1'b0;

        // Even parity: 55 with wrong parity 1, then 81 with correct parity but stop 0
        bus_write(A_CTRL, 8'h01);
        send_rx(12'b0_1_1_01010101_0, 11);
        send_rx(12'b0_0_0_10000001_0, 11);
        repeat (20) @(negedge clk);
        bus_read(A_STATUS, 8'h34, "err_flags_set", 1);
        bus_read(A_DATA,   8'h55, "parity_err_byte_held", 3);
        bus_read(A_DATA,   8'h81, "frame_err_byte", 1);
        bus_read(A_STATUS, 8'h30, "err_flags_sticky", 1);
        bus_write(A_STATUS, 8'hFF);
        bus_read(A_STATUS, 8'h00, "err_flags_cleared", 1);

        // Short low glitch must not produce a byte
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_STATUS, 8'h00, "glitch_rejected", 1);

        // Overrun: DEPTH+1 frames 8N1 without reading
        bus_write(A_CTRL, 8'h00);
        for (int i = 0; i < 5; i++) send_rx({2'b00, 1'b1, ov_bytes[i], 1'b0}, 10);
        repeat (10) @(negedge clk);
        bus_read(A_STATUS, 8'h0C, "overrun_set", 1);
        bus_read(A_DATA, 8'h11, "ov_byte0", 1);
        bus_read(A_DATA, 8'h22, "ov_byte1", 1);
        bus_read(A_DATA, 8'h33, "ov_byte2", 1);
        bus_read(A_DATA, 8'h44, "ov_byte3", 1);
        bus_read(A_DATA, 8'h00, "ov_extra_lost", 1);
        bus_read(A_STATUS, 8'h08, "overrun_sticky", 1);
        bus_write(A_STATUS, 8'h00);
        bus_read(A_STATUS, 8'h00, "overrun_cleared", 1);

        // TX FIFO fill: first byte goes to the shifter, next four fill the FIFO, sixth is dropped
        tx_q.push_back('{bits: 12'b00_1_00000001_0, len: 10});
        tx_q.push_back('{bits: 12'b00_1_00000010_0, len: 10});
        tx_q.push_back('{bits: 12'b00_1_00000011_0, len: 10});
        tx_q.push_back('{bits: 12'b00_1_00000100_0, len: 10});
        tx_q.push_back('{bits: 12'b00_1_00000101_0, len: 10});
        for (int i = 1; i <= 6; i++) bus_write(A_DATA, 8'(i));
        bus_read(A_STATUS, 8'h03, "tx_full_busy", 1);
        repeat (850) @(negedge clk);
        bus_read(A_STATUS, 8'h00, "tx_drained", 1);

        // Reset in the middle of a frame of zeros
        tx_mon_en = 1'b0;
        bus_write(A_DATA, 8'h00);
        repeat (40) @(negedge clk);
        check("tx_low_midframe", {15'd0, tx}, 16'd0);
        #2 reset = 1'b1;
        #1 check("reset_async_tx", {15'd0, tx}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tx_mon_en = 1'b1;
        bus_read(A_STATUS, 8'h00, "status_after_reset", 1);
        repeat (5) @(negedge clk);

        check("read_queue_drained", 16'(exp_q.size()), 16'd0);
        check("tx_queue_drained", 16'(tx_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
